// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its storage array.
package mem_responder_pkg;

  localparam int WORD_SIZE = 16;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } resp_op_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word storage: synchronous write, registered read, contents survive reset.
module mem_array #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  input  logic          re,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write port and read-data register; no reset so storage is preserved.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed latency, one-cycle
// mem_ready pulse, drives the shared data bus only when returning read data.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for read_m xor write_m; both high flags err next cycle
// WAIT  | request latched, counting down; dropped request line aborts
// DONE  | mem_ready for one cycle; read data on the bus while read_m held
module mem_responder #(
  parameter int WORD_SIZE  = mem_responder_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 mem_ready,
  output logic                 mem_busy,
  output logic                 err
);
  import mem_responder_pkg::*;

  // Counter is loaded with LATENCY-1 at acceptance; the move to DONE happens
  // on the edge where it decrements to zero, so DONE starts LATENCY edges
  // after the request was first presented. LATENCY=1 skips WAIT entirely.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam bit               DIRECT   = (LATENCY == 1);

  resp_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  resp_op_t              op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_wdata;
  logic [WORD_SIZE-1:0]  rdata;
  logic                  req_held;
  logic                  drive_en;

  if (WORD_SIZE > ADDR_WIDTH) begin : g_addr_hi
    // Upper address bits alias onto the implemented range.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_WIDTH];
  end

  assign req_held = (op_q == OP_WRITE) ? write_m : read_m;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latched request, latency counter and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, datapath and array access decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (read_m ^ write_m) begin
          op_d   = write_m ? OP_WRITE : OP_READ;
          addr_d = address[ADDR_WIDTH-1:0];
          if (write_m) wdata_d = data;
          cnt_d  = CNT_LOAD;
          if (DIRECT) begin
            // Single-cycle latency: access the array with the live bus values.
            state_d   = DONE;
            mem_we    = write_m;
            mem_re    = read_m;
            mem_addr  = address[ADDR_WIDTH-1:0];
            mem_wdata = data;
          end else begin
            state_d = WAIT;
          end
        end else if (read_m && write_m) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            mem_we  = (op_q == OP_WRITE);
            mem_re  = (op_q == OP_READ);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    mem_ready = (state_q == DONE);
    mem_busy  = (state_q == WAIT);
    drive_en  = (state_q == DONE) && (op_q == OP_READ) && read_m && !write_m;
    err       = err_q;
  end

  assign data = drive_en ? rdata : {WORD_SIZE{1'bz}};

  mem_array #(
    .DW (WORD_SIZE),
    .AW (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_addr),
    .wdata (mem_wdata),
    .raddr (mem_addr),
    .re    (mem_re),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance for the main
// scenarios, LATENCY=1 instance for the back-to-back read case. While the
// bench expects the DUT to leave the bus alone it drives a known value
// itself, so any DUT drive shows up as a corrupted bus value.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  int          total = 0;
  int          bad   = 0;

  // LATENCY=2 instance
  logic        read_m, write_m;
  logic [15:0] address;
  logic        tb_en;
  logic [15:0] tb_val;
  wire  [15:0] data_bus;
  logic        mem_ready, mem_busy, err;
  assign data_bus = tb_en ? tb_val : 16'hzzzz;

  // LATENCY=1 instance
  logic        r1_m, w1_m;
  logic [15:0] a1;
  logic        tb1_en;
  logic [15:0] tb1_val;
  wire  [15:0] bus1;
  logic        ready1, busy1, err1;
  assign bus1 = tb1_en ? tb1_val : 16'hzzzz;

  mem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .read_m(read_m), .write_m(write_m),
    .address(address), .data(data_bus), .mem_ready(mem_ready),
    .mem_busy(mem_busy), .err(err)
  );

  mem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .read_m(r1_m), .write_m(w1_m),
    .address(a1), .data(bus1), .mem_ready(ready1),
    .mem_busy(busy1), .err(err1)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full access on the LATENCY=2 instance, starting at a negedge in IDLE.
  task automatic access2(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] rd_exp, input string tag);
    address = a;
    tb_en   = 1'b1;
    tb_val  = wr ? wd : 16'h0000;
    write_m = wr;
    read_m  = !wr;
    @(negedge clk);
    check_val({tag, ".busy_wait"},  16'(mem_busy),  16'h1);
    check_val({tag, ".ready_wait"}, 16'(mem_ready), 16'h0);
    check_val({tag, ".bus_wait"},   data_bus, wr ? wd : 16'h0000);
    // Latched values must win over bus/address changes during WAIT.
    address = ~a;
    if (wr) tb_val = ~wd;
    else    tb_en  = 1'b0;
    @(negedge clk);
    check_val({tag, ".ready_done"}, 16'(mem_ready), 16'h1);
    check_val({tag, ".busy_done"},  16'(mem_busy),  16'h0);
    check_val({tag, ".bus_done"},   data_bus, wr ? ~wd : rd_exp);
    write_m = 1'b0;
    read_m  = 1'b0;
    tb_en   = 1'b1;
    tb_val  = 16'h0000;
    @(negedge clk);
    check_val({tag, ".ready_after"}, 16'(mem_ready), 16'h0);
    check_val({tag, ".busy_after"},  16'(mem_busy),  16'h0);
    check_val({tag, ".bus_after"},   data_bus, 16'h0000);
  endtask

  // Write on the LATENCY=1 instance: DONE directly after the accepting edge.
  task automatic write_l1(input logic [15:0] a, input logic [15:0] d, input string tag);
    a1      = a;
    w1_m    = 1'b1;
    tb1_en  = 1'b1;
    tb1_val = d;
    @(negedge clk);
    check_val({tag, ".ready"}, 16'(ready1), 16'h1);
    check_val({tag, ".busy"},  16'(busy1),  16'h0);
    check_val({tag, ".bus"},   bus1, d);
    w1_m    = 1'b0;
    tb1_val = 16'h0000;
    @(negedge clk);
    check_val({tag, ".ready_after"}, 16'(ready1), 16'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    read_m = 1'b0; write_m = 1'b0; address = 16'h0; tb_en = 1'b1; tb_val = 16'h0;
    r1_m = 1'b0; w1_m = 1'b0; a1 = 16'h0; tb1_en = 1'b1; tb1_val = 16'h0;
    repeat (2) @(negedge clk);
    check_val("rst.ready", 16'(mem_ready), 16'h0);
    check_val("rst.busy",  16'(mem_busy),  16'h0);
    check_val("rst.err",   16'(err),       16'h0);
    check_val("rst.bus",   data_bus,       16'h0000);
    check_val("rst.ready1", 16'(ready1),   16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1/2: write then read back
    access2(1'b1, 16'h0005, 16'h1234, 16'h0000, "s1_wr");
    access2(1'b0, 16'h0005, 16'h0000, 16'h1234, "s2_rd");

    // 3: upper address bits alias
    access2(1'b1, 16'h0105, 16'hBEEF, 16'h0000, "s3_wr");
    access2(1'b0, 16'h0005, 16'h0000, 16'hBEEF, "s3_rd");

    // 4: both request lines high in IDLE
    read_m = 1'b1; write_m = 1'b1; address = 16'h0005; tb_val = 16'hDEAD;
    @(negedge clk);
    check_val("s4.err",   16'(err),       16'h1);
    check_val("s4.busy",  16'(mem_busy),  16'h0);
    check_val("s4.ready", 16'(mem_ready), 16'h0);
    read_m = 1'b0; write_m = 1'b0; tb_val = 16'h0000;
    @(negedge clk);
    check_val("s4.err_off",   16'(err),       16'h0);
    check_val("s4.busy_off",  16'(mem_busy),  16'h0);
    check_val("s4.ready_off", 16'(mem_ready), 16'h0);
    access2(1'b0, 16'h0005, 16'h0000, 16'hBEEF, "s4_rd");

    // 5a: known prior value, then a write aborted by dropping write_m
    access2(1'b1, 16'h0010, 16'h1111, 16'h0000, "s5_pre");
    address = 16'h0010; write_m = 1'b1; tb_val = 16'hAAAA;
    @(negedge clk);
    check_val("s5a.busy", 16'(mem_busy), 16'h1);
    write_m = 1'b0; tb_val = 16'h0000;
    @(negedge clk);
    check_val("s5a.ready",  16'(mem_ready), 16'h0);
    check_val("s5a.busy_0", 16'(mem_busy),  16'h0);
    @(negedge clk);
    check_val("s5a.ready_1", 16'(mem_ready), 16'h0);

    // 5b: reset asserted mid-WAIT
    address = 16'h0010; write_m = 1'b1; tb_val = 16'hBBBB;
    @(negedge clk);
    check_val("s5b.busy", 16'(mem_busy), 16'h1);
    reset_n = 1'b0; write_m = 1'b0; tb_val = 16'h0000;
    #1;
    check_val("s5b.busy_rst",  16'(mem_busy),  16'h0);
    check_val("s5b.ready_rst", 16'(mem_ready), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("s5b.ready", 16'(mem_ready), 16'h0);
    check_val("s5b.busy",  16'(mem_busy),  16'h0);
    access2(1'b0, 16'h0010, 16'h0000, 16'h1111, "s5_rd");

    // 6: LATENCY=1, back-to-back reads with read_m held
    write_l1(16'h0001, 16'h0A0A, "s6_wr1");
    write_l1(16'h0002, 16'h0B0B, "s6_wr2");
    a1 = 16'h0001; r1_m = 1'b1; tb1_en = 1'b0;
    @(negedge clk);
    check_val("s6.ready_a", 16'(ready1), 16'h1);
    check_val("s6.data_a",  bus1,        16'h0A0A);
    a1 = 16'h0002; tb1_en = 1'b1; tb1_val = 16'h0000;
    @(negedge clk);
    check_val("s6.ready_gap", 16'(ready1), 16'h0);
    check_val("s6.busy_gap",  16'(busy1),  16'h0);
    check_val("s6.bus_gap",   bus1,        16'h0000);
    tb1_en = 1'b0;
    @(negedge clk);
    check_val("s6.ready_b", 16'(ready1), 16'h1);
    check_val("s6.data_b",  bus1,        16'h0B0B);
    r1_m = 1'b0; tb1_en = 1'b1;
    @(negedge clk);
    check_val("s6.ready_end", 16'(ready1), 16'h0);
    check_val("s6.bus_end",   bus1,        16'h0000);
    check_val("s6.err1",      16'(err1),   16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
